add_round_key_stage: RTL and testbench



---
 rtl/add_round_key_stage.sv | 119 +++++++++++
 tb/tb_add_round_key_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage: XORs each state beat with the round key selected by an internal round counter.
// Optional per-byte key parity checking is enabled by defining ARK_PARITY_EN.
module add_round_key_stage #(
  parameter int NUM_ROUNDS = 10,
  parameter int STATE_W    = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_we,
  input  logic [3:0]           key_addr,
  input  logic [STATE_W-1:0]   key_wdata,
  input  logic [STATE_W/8-1:0] key_wpar,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic [STATE_W-1:0]   in_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [STATE_W-1:0]   out_state,
  output logic [3:0]           out_round,
  output logic                 out_last,
  output logic                 out_perr,
  output logic                 seq_err
);

  localparam int         NKEYS    = NUM_ROUNDS + 1;
  localparam int         NBYTES   = STATE_W / 8;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  logic [STATE_W-1:0] key_bank [NKEYS];
  logic [3:0]         rnd_reg;
  logic [3:0]         rnd_next;
  logic [3:0]         idx;
  logic               accept;
  logic [STATE_W-1:0] key_sel;
  logic               perr_next;

  logic               out_valid_reg;
  logic [STATE_W-1:0] out_state_reg;
  logic [3:0]         out_round_reg;
  logic               out_last_reg;
  logic               out_perr_reg;
  logic               seq_err_reg;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign idx      = in_first ? 4'd0 : rnd_reg;
  // Read happens before the same-edge write, so a colliding beat sees the old key.
  assign key_sel  = key_bank[idx];
  assign rnd_next = accept ? ((idx == LAST_IDX) ? 4'd0 : idx + 4'd1) : rnd_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NKEYS; i++) key_bank[i] <= '0;
    end else if (key_we && key_addr <= LAST_IDX) begin
      key_bank[key_addr] <= key_wdata;
    end
  end

`ifdef ARK_PARITY_EN
  logic [NBYTES-1:0] par_bank [NKEYS];
  logic [NBYTES-1:0] par_calc;

  // Byte i occupies the i-th byte from the MSB end; its parity lands in bit i.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_par
      assign par_calc[gi] = ^key_sel[STATE_W-1-8*gi -: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NKEYS; i++) par_bank[i] <= '0;
    end else if (key_we && key_addr <= LAST_IDX) begin
      par_bank[key_addr] <= key_wpar;
    end
  end

  assign perr_next = (par_calc != par_bank[idx]);
`else
  logic unused_wpar;
  assign unused_wpar = ^key_wpar;
  assign perr_next   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_state_reg <= '0;
      out_round_reg <= '0;
      out_last_reg  <= 1'b0;
      out_perr_reg  <= 1'b0;
      seq_err_reg   <= 1'b0;
    end else begin
      rnd_reg <= rnd_next;
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_state_reg <= in_state ^ key_sel;
        out_round_reg <= idx;
        out_last_reg  <= (idx == LAST_IDX);
        out_perr_reg  <= perr_next;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      // A continuation beat with no sequence in progress is still processed, but flagged.
      if (accept && !in_first && rnd_reg == 4'd0) seq_err_reg <= 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_state = out_state_reg;
  assign out_round = out_round_reg;
  assign out_last  = out_last_reg;
  assign out_perr  = out_perr_reg;
  assign seq_err   = seq_err_reg;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Scoreboard bench for add_round_key_stage: expected beats queued at accept, compared when output handshakes.
module tb_add_round_key_stage;

  typedef struct packed {
    logic [127:0] state;
    logic [3:0]   round;
    logic         last;
    logic         perr;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         key_we;
  logic [3:0]   key_addr;
  logic [127:0] key_wdata;
  logic [15:0]  key_wpar;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_last;
  logic         out_perr;
  logic         seq_err;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] mkey [11];
  logic [15:0]  mpar [11];
  logic [3:0]   mrnd;
  logic         mseq;

  localparam logic [127:0] FIPS_KEY1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_IN   = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] FIPS_OUT  = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;

  add_round_key_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_wdata (key_wdata),
    .key_wpar  (key_wpar),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_round (out_round),
    .out_last  (out_last),
    .out_perr  (out_perr),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] kpar(input logic [127:0] k);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ^k[127-8*i -: 8];
    return p;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Output side: one scoreboard pop per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] beat round=%0d last=%0d perr=%0d state=%h", out_round, out_last, out_perr, out_state);
        check_eq("out_state", out_state, mon_e.state);
        check_eq("out_round", out_round, mon_e.round);
        check_eq("out_last",  out_last,  mon_e.last);
        check_eq("out_perr",  out_perr,  mon_e.perr);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 11; i++) begin
      mkey[i] = '0;
      mpar[i] = '0;
    end
    mrnd = '0;
    mseq = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_state", out_state, '0);
    check_eq("rst_out_round", out_round, '0);
    check_eq("rst_out_last",  out_last,  1'b0);
    check_eq("rst_out_perr",  out_perr,  1'b0);
    check_eq("rst_seq_err",   seq_err,   1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write_key(input logic [3:0] a, input logic [127:0] d, input logic [15:0] p);
    key_we = 1'b1; key_addr = a; key_wdata = d; key_wpar = p;
    @(posedge clk);
    #1;
    key_we = 1'b0;
    if (a <= 4'd10) begin
      mkey[a] = d;
      mpar[a] = p;
    end
  endtask

  // Drives one beat; any key write already set up completes on the same edge as the accept.
  task automatic send_beat(input logic first, input logic [127:0] st, output int waits);
    exp_t       e;
    logic [3:0] idx;
    in_valid = 1'b1; in_first = first; in_state = st; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 1'b0, 1'b1);
    end else begin
      idx = first ? 4'd0 : mrnd;
      if (!first && mrnd == 4'd0) mseq = 1'b1;
      e.state = st ^ mkey[idx];
      e.round = idx;
      e.last  = (idx == 4'd10);
`ifdef ARK_PARITY_EN
      e.perr  = (kpar(mkey[idx]) != mpar[idx]);
`else
      e.perr  = 1'b0;
`endif
      sb.push_back(e);
      mrnd = (idx == 4'd10) ? 4'd0 : idx + 4'd1;
    end
    @(posedge clk);
    #1;
    if (key_we) begin
      if (key_addr <= 4'd10) begin
        mkey[key_addr] = key_wdata;
        mpar[key_addr] = key_wpar;
      end
      key_we = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           w;
    logic [127:0] k;
    rst_n = 1'b0; key_we = 1'b0; key_addr = '0; key_wdata = '0; key_wpar = '0;
    in_valid = 1'b0; in_first = 1'b0; in_state = '0; out_ready = 1'b1;
    #1;
    do_reset();
    check_eq("rst_in_ready", in_ready, 1'b1);

    // Idle continuation beat right after reset: key 0, round 0, sticky seq_err.
    write_key(4'd0, rand128(), '0);
    send_beat(1'b0, rand128(), w);
    check_eq("seq_err_idle", seq_err, 1'b1);
    drain();
    check_eq("seq_err_sticky", seq_err, 1'b1);

    // Reset with a held output beat: beat dropped, keys cleared.
    out_ready = 1'b0;
    send_beat(1'b1, rand128(), w);
    do_reset();
    out_ready = 1'b1;
    #1;
    check_eq("post_rst_valid", out_valid, 1'b0);
    send_beat(1'b1, rand128(), w);
    drain();

    // Load bank, then a full back-to-back sequence.
    for (int r = 0; r <= 10; r++) begin
      k = (r == 1) ? FIPS_KEY1 : rand128();
      write_key(4'(r), k, kpar(k));
    end
    for (int r = 0; r <= 10; r++) begin
      send_beat(r == 0, rand128(), w);
      check_eq("b2b_wait", w, 0);
    end
    drain();
    check_eq("seq_err_clean", seq_err, 1'b0);

    // FIPS-197 round-1 vector, held under backpressure.
    send_beat(1'b1, rand128(), w);
    send_beat(1'b0, FIPS_IN, w);
    out_ready = 1'b0;
    in_valid = 1'b1; in_first = 1'b0; in_state = rand128();
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready",  in_ready,  1'b0);
      check_eq("bp_out_valid", out_valid, 1'b1);
      check_eq("fips_state",   out_state, FIPS_OUT);
      check_eq("fips_round",   out_round, 4'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(1'b0, in_state, w);
    check_eq("bp_release_wait", w, 0);
    drain();

    // Restart mid-sequence, then same-cycle key1 write vs round-1 accept.
    send_beat(1'b1, rand128(), w);
    key_we = 1'b1; key_addr = 4'd1; key_wdata = '1; key_wpar = kpar('1);
    send_beat(1'b0, rand128(), w);
    send_beat(1'b1, rand128(), w);
    send_beat(1'b0, rand128(), w);
    drain();

    // Key 2 stored with a wrong byte-0 parity bit, then corrected.
    write_key(4'd2, '0, 16'h0001);
    send_beat(1'b1, rand128(), w);
    send_beat(1'b0, rand128(), w);
    send_beat(1'b0, rand128(), w);
    drain();
    k = rand128();
    write_key(4'd2, k, kpar(k));
    send_beat(1'b1, rand128(), w);
    send_beat(1'b0, rand128(), w);
    send_beat(1'b0, rand128(), w);
    drain();

    check_eq("seq_err_final", seq_err, mseq);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
